// File: rtl/sync_debounce.sv
// Posedge sync stage plus a two-state debouncer with registered rise/fall pulses.
// Optional EDGE_CNT_EN macro adds an 8-bit count of accepted dout transitions.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       dout,
  output logic       rise,
  output logic       fall,
  output logic       busy
`ifdef EDGE_CNT_EN
  ,
  output logic [7:0] edge_cnt
`endif
);

  localparam logic [0:0] STABLE = 1'b0;
  localparam logic [0:0] CHECK  = 1'b1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  assign busy = (state == CHECK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 1'b0;
      dout   <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      cnt    <= '0;
      state  <= STABLE;
    end else begin
      sync_q <= din;
      rise   <= 1'b0;
      fall   <= 1'b0;
      case (state)
        STABLE: begin
          if (sync_q != dout) begin
            state <= CHECK;
            cnt   <= '0;
          end
        end
        CHECK: begin
          // A return to the old level aborts qualification without a pulse.
          if (sync_q == dout) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            dout  <= sync_q;
            rise  <= sync_q;
            fall  <= ~sync_q;
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef EDGE_CNT_EN
  // Counts on the cycle the pulse is registered, so it tracks dout changes exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      edge_cnt <= 8'd0;
    else if (state == CHECK && sync_q != dout && cnt == LAST)
      edge_cnt <= edge_cnt + 8'd1;
  end
`endif

endmodule
